cond_flag_unit: RTL
===================

Name: cond_flag_unit

Overview:
Consumer side of the ALU flag path. Holds the architectural NZCV status register and evaluates each instruction's 4-bit condition field against it. Gates the instruction's write-enables (register, memory, PC) and updates NZCV from the ALU flag outputs when the instruction executes. Sits between decode and writeback. Also provides a one-entry shadow NZCV for save/restore and a saturating squash counter.

Parameters:
CNT_W, 16, width of the squashed-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
InValid  input  1  instruction present this cycle
Cond  input  4  condition field
ALUFlags  input  4  {N,Z,C,V} from the ALU flag generator for this instruction
FlagW  input  2  [1]=update N,Z; [0]=update C,V
PCS  input  1  instruction writes PC
RegW  input  1  instruction writes register file
MemW  input  1  instruction writes memory
Stall  input  1  freeze the unit
SaveFlags  input  1  copy NZCV to shadow
RestoreFlags  input  1  load NZCV from shadow
OutValid  output  1  registered outputs below are valid
CondEx  output  1  registered condition result
PCSrc  output  1  PCS & CondEx, registered
RegWrite  output  1  RegW & CondEx, registered
MemWrite  output  1  MemW & CondEx, registered
Flags  output  4  current NZCV register {N,Z,C,V}
SquashCount  output  CNT_W  number of squashed instructions

Behaviour:
- Reset is synchronous and active-high. It has priority over everything else. It clears NZCV, the shadow, SquashCount, OutValid, CondEx, PCSrc, RegWrite and MemWrite to 0.
- Condition evaluation is combinational (ce) on the current NZCV register:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 is treated as AL, 1.
- Latency: one cycle. Inputs sampled at edge t appear on the outputs after edge t.
  - OutValid <= InValid.
  - CondEx <= ce & InValid.
  - Gated write-enables <= enable & ce & InValid.
  - When InValid=0, all gated outputs are 0 the next cycle.
- Stall=1 has the highest priority below reset. No register changes at all: NZCV, shadow, counter and all outputs hold. Save, restore and flag update are all ignored.
- NZCV update occurs when InValid & ce & ~Stall:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - The unselected pair holds.
  - A squashed instruction (ce=0) never changes flags.
- The next instruction evaluates against the updated NZCV. Back-to-back dependence therefore works with no bubble.
- Priority on NZCV each non-stalled cycle: RestoreFlags > ALU update > hold.
- Save/restore:
  - SaveFlags loads the shadow with NZCV as it was before this edge.
  - Save and restore in the same cycle is a swap: the shadow gets the old NZCV and NZCV gets the old shadow.
- SquashCount increments by 1 when InValid & ~ce & ~Stall. It saturates at all-ones with no wrap.
- Flags output is the NZCV register directly. It has no extra pipeline stage.

Test Plan:
- Reset, then Cond=0000 (EQ) with InValid=1 and RegW=1 → after one edge: CondEx=0, RegWrite=0, SquashCount=1, Flags=0000.
- Cond=1110, FlagW=11, ALUFlags=0100 → Flags=0100. Next cycle Cond=0000, RegW=1 → RegWrite=1 with no bubble.
- Flags=1000 (N=1,V=0), FlagW=01, ALUFlags=0011 → Flags=1011. Then Cond=1010 (GE, N==V) → CondEx=1. Then Cond=1011 (LT) → CondEx=0.
- Squash check: Cond=0001 (NE) with Z=1, FlagW=11, ALUFlags=0000 → flags unchanged, MemWrite=0, SquashCount increments.
- Stall=1 for 3 cycles with InValid=1, SaveFlags=1, and a flag-writing AL instruction → NZCV, shadow, SquashCount and all outputs hold their prior values.
- Flags=0110 and shadow=1001, assert SaveFlags and RestoreFlags together with an AL FlagW=11 instruction → Flags=1001, shadow=0110. Restore overrides the ALU update.
- Force SquashCount to all-ones minus 1, then issue 3 squashed instructions → SquashCount saturates at all-ones.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Condition evaluation and NZCV status register for the writeback side of the ALU flag path.
// Gates register/memory/PC write-enables, keeps a one-entry shadow NZCV and a saturating squash counter.
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             Stall,
  input  logic             SaveFlags,
  input  logic             RestoreFlags,
  output logic             OutValid,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCount
);

  logic [3:0]       nzcv_q, nzcv_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             cond_ex_q, cond_ex_d;
  logic             pc_src_q, pc_src_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic ce;
  logic exec;

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

  always_comb begin
    ce = 1'b1;
    unique case (Cond)
      4'b0000: ce = flag_z;
      4'b0001: ce = ~flag_z;
      4'b0010: ce = flag_c;
      4'b0011: ce = ~flag_c;
      4'b0100: ce = flag_n;
      4'b0101: ce = ~flag_n;
      4'b0110: ce = flag_v;
      4'b0111: ce = ~flag_v;
      4'b1000: ce = flag_c & ~flag_z;
      4'b1001: ce = ~flag_c | flag_z;
      4'b1010: ce = (flag_n == flag_v);
      4'b1011: ce = (flag_n != flag_v);
      4'b1100: ce = ~flag_z & (flag_n == flag_v);
      4'b1101: ce = flag_z | (flag_n != flag_v);
      default: ce = 1'b1;
    endcase
  end

  assign exec = InValid & ce;

  always_comb begin
    nzcv_d      = nzcv_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    cond_ex_d   = cond_ex_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;

    if (!Stall) begin
      out_valid_d = InValid;
      cond_ex_d   = exec;
      pc_src_d    = PCS & exec;
      reg_write_d = RegW & exec;
      mem_write_d = MemW & exec;

      // Shadow always captures the pre-edge NZCV, which makes save+restore a swap.
      if (SaveFlags) shadow_d = nzcv_q;

      if (RestoreFlags) begin
        nzcv_d = shadow_q;
      end else if (exec) begin
        if (FlagW[1]) nzcv_d[3:2] = ALUFlags[3:2];
        if (FlagW[0]) nzcv_d[1:0] = ALUFlags[1:0];
      end

      if (InValid && !ce && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q      <= 4'b0000;
      shadow_q    <= 4'b0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      nzcv_q      <= nzcv_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      cond_ex_q   <= cond_ex_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign OutValid    = out_valid_q;
  assign CondEx      = cond_ex_q;
  assign PCSrc       = pc_src_q;
  assign RegWrite    = reg_write_q;
  assign MemWrite    = mem_write_q;
  assign Flags       = nzcv_q;
  assign SquashCount = cnt_q;

endmodule
